// File: rtl/pwm_tone_sequencer.sv
// Collision sound sequencer: a good or bad collision event starts a short
// ascending or descending run of notes. Each note lasts NOTE_TICKS enabled
// cycles. The current note index drives an external period lookup, and the
// returned period drives a PWM generator whose duty cycle is set by volume.
module pwm_tone_sequencer #(
  parameter int CNT_W      = 19,
  parameter int NOTE_W     = 6,
  parameter int SEQ_LEN    = 4,
  parameter int NOTE_TICKS = 2500000,
  parameter int GOOD_BASE  = 12,
  parameter int BAD_BASE   = 20
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic              good_collision,
  input  logic              bad_collision,
  input  logic [1:0]        volume,
  input  logic [CNT_W-1:0]  period_in,
  output logic [NOTE_W-1:0] note_idx,
  output logic              busy,
  output logic              out
);

  localparam int STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int DUR_W  = $clog2(NOTE_TICKS);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SEQ_LEN - 1);
  localparam logic [DUR_W-1:0]  DUR_LAST  = DUR_W'(NOTE_TICKS - 1);
  localparam logic [NOTE_W-1:0] GOOD_NOTE = NOTE_W'(GOOD_BASE);
  localparam logic [NOTE_W-1:0] BAD_NOTE  = NOTE_W'(BAD_BASE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY_GOOD = 2'd1,
    PLAY_BAD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic [CNT_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic                out_q, out_d;
  logic                busy_q;

  logic                playing;
  logic                event_hit;
  logic [CNT_W-1:0]    duty;

  assign playing   = (state_q != IDLE);
  assign event_hit = enable && (good_collision || bad_collision);

  // Quieter volume settings halve the high time once more per step.
  assign duty = period_in >> ({1'b0, volume} + 3'd1);

  // Note index offered to the period lookup, wrapping modulo 2^NOTE_W.
  always_comb begin
    note_idx = '0;
    case (state_q)
      PLAY_GOOD: note_idx = GOOD_NOTE + NOTE_W'(step_q);
      PLAY_BAD:  note_idx = BAD_NOTE - NOTE_W'(step_q);
      default:   note_idx = '0;
    endcase
  end

  // Next-state logic: events restart playback from any state; otherwise the
  // note timer and PWM counter advance only while enabled and playing.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    dur_cnt_d = dur_cnt_q;
    pwm_cnt_d = pwm_cnt_q;
    if (event_hit) begin
      state_d   = bad_collision ? PLAY_BAD : PLAY_GOOD;
      step_d    = '0;
      dur_cnt_d = '0;
      pwm_cnt_d = '0;
    end else if (enable && playing) begin
      if (dur_cnt_q == DUR_LAST) begin
        dur_cnt_d = '0;
        pwm_cnt_d = '0;
        if (step_q == STEP_LAST) begin
          state_d = IDLE;
          step_d  = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end else begin
        dur_cnt_d = dur_cnt_q + DUR_W'(1);
        // A rest or a period that shrank below the counter both restart at 0.
        if ((period_in == '0) || (pwm_cnt_q >= period_in - CNT_W'(1))) begin
          pwm_cnt_d = '0;
        end else begin
          pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
        end
      end
    end
    out_d = enable && playing && (period_in != '0) && (volume != 2'd3) &&
            (pwm_cnt_q < duty);
  end

  // State register with registered busy and audio outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      dur_cnt_q <= '0;
      pwm_cnt_q <= '0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      dur_cnt_q <= dur_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
      out_q     <= out_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  assign busy = busy_q;
  assign out  = out_q;

endmodule

// File: tb/tb_pwm_tone_sequencer.sv
// Bench for pwm_tone_sequencer with short notes (16 cycles, 4 notes).
// A reference model tracks playback as "mode + enabled cycles elapsed in the
// sequence" and derives note, PWM phase and output level arithmetically.
module tb_pwm_tone_sequencer;

  localparam int NT = 16;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        enable;
  logic        good_collision;
  logic        bad_collision;
  logic [1:0]  volume;
  logic [18:0] period_in;
  logic [5:0]  note_idx;
  logic        busy;
  logic        out;

  logic [18:0] period_tbl [64];

  int checks = 0;
  int fails  = 0;
  int cycle_no = 0;

  // Reference model state: 0 idle, 1 good run, 2 bad run.
  int   m_mode = 0;
  int   m_t    = 0;
  logic exp_out = 1'b0;

  pwm_tone_sequencer #(
    .CNT_W(19), .NOTE_W(6), .SEQ_LEN(SL), .NOTE_TICKS(NT),
    .GOOD_BASE(12), .BAD_BASE(20)
  ) dut (
    .clk(clk), .nrst(nrst), .enable(enable),
    .good_collision(good_collision), .bad_collision(bad_collision),
    .volume(volume), .period_in(period_in),
    .note_idx(note_idx), .busy(busy), .out(out)
  );

  always #5 clk = ~clk;

  assign period_in = period_tbl[note_idx];

  function automatic int m_note(input int mode, input int t);
    if (mode == 1) return (12 + t / NT) & 63;
    if (mode == 2) return (20 - t / NT) & 63;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cycle_no, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_t     = 0;
    exp_out = 1'b0;
  endtask

  // One clock: drive inputs, advance the model at the edge, check after it.
  task automatic step(input logic en, input logic g, input logic b);
    int nt, p, d;
    enable = en;
    good_collision = g;
    bad_collision = b;
    @(posedge clk);
    cycle_no++;
    nt = m_t % NT;
    p = int'(period_tbl[m_note(m_mode, m_t)]);
    d = p >> (int'(volume) + 1);
    exp_out = en && (m_mode != 0) && (p != 0) && (volume != 2'd3) && ((p != 0) ? ((nt % p) < d) : 1'b0);
    if (en && (g || b)) begin
      $display("cycle %0d: %s collision accepted", cycle_no, b ? "bad" : "good");
      m_mode = b ? 2 : 1;
      m_t = 0;
    end else if (en && m_mode != 0) begin
      m_t++;
      if (m_t == SL * NT) begin
        m_mode = 0;
        m_t = 0;
      end
    end else if (!en && (g || b)) begin
      $display("cycle %0d: collision while disabled, dropped", cycle_no);
    end
    #1;
    check("busy", busy, m_mode != 0);
    check("note_idx", note_idx, m_note(m_mode, m_t));
    check("out", out, exp_out);
    good_collision = 1'b0;
    bad_collision = 1'b0;
  endtask

  // Run n enabled idle-input cycles, counting cycles that end with busy=1.
  task automatic run(input int n, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  initial begin
    int bc, total;
    int p_choices [8];
    p_choices = '{0, 1, 2, 3, 5, 7, 8, 13};
    for (int i = 0; i < 64; i++) period_tbl[i] = 19'd8;
    nrst = 1'b0;
    enable = 1'b0;
    good_collision = 1'b0;
    bad_collision = 1'b0;
    volume = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_out", out, 0);
    check("reset_note", note_idx, 0);
    #2 nrst = 1'b1;
    model_reset();

    // 1: good run at 50% duty, 64 busy cycles.
    step(1'b1, 1'b1, 1'b0);
    check("t1_first_note", note_idx, 12);
    run(70, bc);
    check("t1_busy_len", bc + 1, 64);

    // 2: simultaneous events, bad wins.
    step(1'b1, 1'b1, 1'b1);
    check("t2_bad_prio", note_idx, 20);
    run(70, bc);

    // 3: bad restarts a good run at step 2.
    step(1'b1, 1'b1, 1'b0);
    run(2 * NT, bc);
    check("t3_at_step2", note_idx, 14);
    step(1'b1, 1'b0, 1'b1);
    check("t3_restart_note", note_idx, 20);
    run(70, bc);
    check("t3_busy_len", bc + 1, 64);

    // 4: volume levels, then a rest on note 13.
    for (int v = 1; v <= 3; v++) begin
      volume = 2'(v);
      step(1'b1, 1'b1, 1'b0);
      run(70, bc);
    end
    volume = 2'd0;
    period_tbl[13] = 19'd0;
    step(1'b1, 1'b1, 1'b0);
    run(70, bc);
    period_tbl[13] = 19'd8;

    // 5: freeze for 10 cycles at dur_cnt=5 of note 1, events dropped.
    step(1'b1, 1'b1, 1'b0);
    total = 1;
    run(NT + 5, bc);
    total += bc;
    for (int i = 0; i < 10; i++) step(1'b0, i == 3, i == 6);
    check("t5_frozen_note", note_idx, 13);
    run(50, bc);
    total += bc;
    check("t5_enabled_busy", total, 64);

    // 6: asynchronous reset between edges mid-note.
    step(1'b1, 1'b1, 1'b0);
    run(20, bc);
    #2 nrst = 1'b0;
    #1;
    check("t6_async_busy", busy, 0);
    check("t6_async_out", out, 0);
    check("t6_async_note", note_idx, 0);
    model_reset();
    @(posedge clk);
    #3 nrst = 1'b1;
    run(8, bc);
    check("t6_stays_idle", bc, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) volume = 2'($urandom_range(0, 3));
      if (m_mode == 0 && $urandom_range(0, 3) == 0)
        period_tbl[$urandom_range(0, 63)] = 19'(p_choices[$urandom_range(0, 7)]);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 119) == 0, $urandom_range(0, 149) == 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
